mat_operand_fetch: RTL

MAT_OPERAND_FETCH -- requirements
Module: mat_operand_fetch

---
 rtl/mat_operand_fetch.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/mat_operand_fetch.sv
// Matrix operand fetch: sweeps every (row of A, column of B) pair, reads the
// ACOL elements of each from row-major A and B memories, and presents them
// as packed vectors with a valid/ready handshake to a dot-product engine.
// Optional feature macro AROW_CACHE_EN: fetch the A row only at column 0
// and reuse the held A vector for the remaining columns of that row.
module mat_operand_fetch #(
    parameter int AROW         = 2,
    parameter int ACOL         = 2,
    parameter int BCOL         = 2,
    parameter int A_DATA_WIDTH = 8,
    parameter int B_DATA_WIDTH = 8,
    localparam int AW   = (AROW * ACOL > 1) ? $clog2(AROW * ACOL) : 1,
    localparam int BW   = (ACOL * BCOL > 1) ? $clog2(ACOL * BCOL) : 1,
    localparam int RW   = (AROW > 1) ? $clog2(AROW) : 1,
    localparam int CW   = (BCOL > 1) ? $clog2(BCOL) : 1
) (
    input  logic                         Clock,
    input  logic                         Reset,
    input  logic                         Start,
    output logic                         Busy,
    output logic                         Done,
    output logic [AW-1:0]                A_Addr,
    output logic                         A_RdEn,
    input  logic [A_DATA_WIDTH-1:0]      A_RdData,
    output logic [BW-1:0]                B_Addr,
    output logic                         B_RdEn,
    input  logic [B_DATA_WIDTH-1:0]      B_RdData,
    output logic [ACOL*A_DATA_WIDTH-1:0] Out_A,
    output logic [ACOL*B_DATA_WIDTH-1:0] Out_B,
    output logic [RW-1:0]                Out_Row,
    output logic [CW-1:0]                Out_Col,
    output logic                         Out_Valid,
    input  logic                         Out_Ready,
    output logic                         Out_Last
);

    // FETCH counter runs 0..ACOL: reads issue in 0..ACOL-1, data lands in 1..ACOL.
    localparam int CNTW = $clog2(ACOL + 1);

    typedef enum logic [1:0] {IDLE, FETCH, PRESENT} state_t;

    state_t                         state_q, state_d;
    logic [CNTW-1:0]                cnt_q, cnt_d;
    logic [RW-1:0]                  row_q, row_d;
    logic [CW-1:0]                  col_q, col_d;
    logic [ACOL*A_DATA_WIDTH-1:0]   avec_q, avec_d;
    logic [ACOL*B_DATA_WIDTH-1:0]   bvec_q, bvec_d;
    logic                           done_q, done_d;

    logic rd_phase;
    logic cap_phase;
    logic a_fetch_en;
    logic is_last;

    assign rd_phase  = (state_q == FETCH) && (cnt_q < CNTW'(ACOL));
    assign cap_phase = (state_q == FETCH) && (cnt_q != '0);
    assign is_last   = (row_q == RW'(AROW - 1)) && (col_q == CW'(BCOL - 1));

`ifdef AROW_CACHE_EN
    // The A row only changes when the column index restarts at 0.
    assign a_fetch_en = (col_q == '0);
`else
    assign a_fetch_en = 1'b1;
`endif

    assign A_RdEn    = rd_phase && a_fetch_en;
    assign B_RdEn    = rd_phase;
    assign A_Addr    = A_RdEn ? AW'(32'(row_q) * ACOL + 32'(cnt_q)) : '0;
    assign B_Addr    = B_RdEn ? BW'(32'(cnt_q) * BCOL + 32'(col_q)) : '0;
    assign Busy      = (state_q != IDLE);
    assign Done      = done_q;
    assign Out_Valid = (state_q == PRESENT);
    assign Out_Last  = Out_Valid && is_last;
    assign Out_Row   = row_q;
    assign Out_Col   = col_q;
    assign Out_A     = avec_q;
    assign Out_B     = bvec_q;

    // Sequencer: next state, fetch counter, pair indices and done pulse.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        row_d   = row_q;
        col_d   = col_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (Start) begin
                    state_d = FETCH;
                    cnt_d   = '0;
                end
            end
            FETCH: begin
                if (cnt_q == CNTW'(ACOL)) begin
                    state_d = PRESENT;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            PRESENT: begin
                if (Out_Ready) begin
                    if (is_last) begin
                        state_d = IDLE;
                        row_d   = '0;
                        col_d   = '0;
                        done_d  = 1'b1;
                    end else begin
                        state_d = FETCH;
                        if (col_q == CW'(BCOL - 1)) begin
                            col_d = '0;
                            row_d = row_q + 1'b1;
                        end else begin
                            col_d = col_q + 1'b1;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Operand capture: read data for element k arrives at counter value k+1.
    always_comb begin
        avec_d = avec_q;
        bvec_d = bvec_q;
        for (int k = 0; k < ACOL; k++) begin
            if (cap_phase && (cnt_q == CNTW'(k + 1))) begin
                if (a_fetch_en) begin
                    avec_d[k*A_DATA_WIDTH +: A_DATA_WIDTH] = A_RdData;
                end
                bvec_d[k*B_DATA_WIDTH +: B_DATA_WIDTH] = B_RdData;
            end
        end
    end

    // State and operand registers; reset clears everything so all outputs read 0.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            row_q   <= '0;
            col_q   <= '0;
            avec_q  <= '0;
            bvec_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            row_q   <= row_d;
            col_q   <= col_d;
            avec_q  <= avec_d;
            bvec_q  <= bvec_d;
            done_q  <= done_d;
        end
    end

endmodule
